alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single combinational MIPS ALU between two requesters: port 0 is the core
//  execute stage and port 1 is the branch/address helper. Round-robin arbitration and
//  valid/ready handshakes on each side. Operands are registered, then the ALU result and
//  zero flag are captured and held until the owning requester accepts them.
//  Sits between the requesters and the ALU instance; drives its function and operand inputs.
// PARAMETERS
//  DATA_W      32  operand/result width; must match the ALU width
//  MUL_CYCLES  3   cycles ALU inputs are held for function 3'b101 (only used with the macro below)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  req_valid_0/1 in  1       request valid, per requester
//  req_ready_0/1 out 1       request accepted when valid & ready
//  req_fun_0/1  in   3       ALU function: 000 AND, 001 OR, 010 ADD, 100 SUB, 101 MUL, 110 SLTU
//  req_a_0/1    in   DATA_W  operand 1
//  req_b_0/1    in   DATA_W  operand 2
//  rsp_valid_0/1 out 1       result valid for that requester
//  rsp_ready_0/1 in  1       response consumed when valid & ready
//  rsp_data     out  DATA_W  captured ALU result (shared; qualified by rsp_valid_x)
//  rsp_zero     out  1       captured zero flag
//  alu_fun      out  3       to ALU function input
//  alu_in1/2    out  DATA_W  to ALU operand inputs
//  alu_out      in   DATA_W  from ALU result
//  alu_zero     in   1       from ALU zero flag
// BEHAVIOUR
//  - Reset: FSM=IDLE, all req_ready/rsp_valid=0, rsp_data=0, rsp_zero=0, alu_fun/in1/in2=0,
//    round-robin pointer=0 (port 0 has priority first).
//  - FSM: IDLE -> EXEC -> RESP -> IDLE. One operation in flight; no pipelining.
//  - IDLE: req_ready asserted combinationally to the grant winner only. If both are valid,
//    the port != last-granted wins. Single valid port wins regardless of pointer.
//    On accept: register fun/a/b and owner id, toggle pointer to owner, go to EXEC.
//  - EXEC: alu_* driven from registers; at the end of the cycle capture alu_out/alu_zero -> RESP.
//  - RESP: rsp_valid_<owner>=1, data/zero stable; on rsp_ready_<owner> go to IDLE. The next
//    request can be accepted in the cycle after the handshake (no same-cycle re-grant).
//  - Latency: accept in cycle N -> rsp_valid at N+2 (non-MUL). Best throughput 1 op per 3 cycles.
//  - alu_* hold their last values outside EXEC, which keeps ALU toggling down.
//  - Unused functions 011/111 pass through unchanged; the ALU returns 0 and zero=1.
//  - MUL returns the low DATA_W bits. SLTU compares unsigned. No overflow detection.
//  - Reset asserted in any state aborts the operation: the response is dropped and the
//    reset values above are restored in the next cycle.
//  - req_* inputs are ignored when the port is not ready; requesters hold them stable until accepted.
// CONFIGURATION
//  ALU_SHARE_MUL_MULTICYCLE_EN defined: for fun 101, EXEC lasts MUL_CYCLES cycles (down-counter,
//    capture on the last one), so MUL latency is MUL_CYCLES+1. The ALU multiply is then
//    constrained as a multicycle path.
//  Macro undefined: all functions use the 1-cycle EXEC; the counter is not built.
// STRUCTURE
//  Shared package mips_pkg: ALU function localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
//    ALU_MUL, ALU_SLTU), FSM state encodings (ST_IDLE, ST_EXEC, ST_RESP), DATA_W default.
//  Sub-module: rr_arb2, a 2-way round-robin grant with a pointer-update enable.
//    The FSM, operand registers and result capture stay in this module.
//  The ALU is instantiated outside this block, alongside it.
// TESTING (bench instantiates the real ALU behind this block)
//  1 Only port 0: ADD 5+7 -> rsp_valid_0 two cycles after accept, rsp_data=12, rsp_zero=0.
//  2 Both valid from reset: p0 SUB 9-9, p1 OR 0xF0|0x0F -> p0 first (data 0, zero=1),
//    then p1 (0xFF). Repeat both valid -> p0 (RR) after p1.
//  3 Backpressure: hold rsp_ready_1=0 for 5 cycles -> rsp_data/zero stable, req_ready_0=0.
//  4 SLTU 1 < 0xFFFFFFFF -> 1. Fun 011 with any operands -> data 0, zero=1.
//  5 MUL 0x10000*0x10000 -> 0, zero=1. With the macro and MUL_CYCLES=3, rsp_valid comes
//    4 cycles after accept; without the macro, 2 cycles.
//  6 Assert rst during EXEC and during RESP -> next cycle all outputs at reset values,
//    no rsp_valid; a fresh request is served normally afterwards.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS constants: ALU function codes, ALU share FSM states and the default datapath width.
package mips_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_MUL  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. A tie goes to the priority port; after a granted update the
// other port becomes the priority port.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] grant
);

  logic prio_reg;  // port that wins when both request

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = prio_reg ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_reg <= 1'b0;
    end else if (update_en && (|grant)) begin
      prio_reg <= grant[0];
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational MIPS ALU between the execute stage (port 0) and the branch/address
// helper (port 1). Optional macro ALU_SHARE_MUL_MULTICYCLE_EN stretches EXEC to MUL_CYCLES for MUL.
module alu_share_arbiter
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [2:0]        req_fun_0,
  input  logic [2:0]        req_fun_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [DATA_W-1:0] req_b_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_0,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_zero,
  output logic [2:0]        alu_fun,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_zero
);

  if (MUL_CYCLES < 1) begin : g_mul_cycles_check
    $error("MUL_CYCLES must be at least 1");
  end

  state_t            state_reg, state_next;
  logic              owner_reg;
  logic [2:0]        alu_fun_reg;
  logic [DATA_W-1:0] alu_in1_reg, alu_in2_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_zero_reg;

  logic [1:0]        grant;
  logic              idle_open, accept, exec_last, rsp_hs;
  logic [2:0]        sel_fun;

  // Grants are only offered in IDLE, and never while reset is held.
  assign idle_open = (state_reg == ST_IDLE) && !rst;
  assign accept    = idle_open && (|grant);
  assign sel_fun   = grant[1] ? req_fun_1 : req_fun_0;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       ({req_valid_1, req_valid_0}),
    .update_en (accept),
    .grant     (grant)
  );

  assign req_ready_0 = idle_open && grant[0];
  assign req_ready_1 = idle_open && grant[1];
  assign rsp_valid_0 = (state_reg == ST_RESP) && !owner_reg;
  assign rsp_valid_1 = (state_reg == ST_RESP) && owner_reg;
  assign rsp_hs      = owner_reg ? rsp_ready_1 : rsp_ready_0;

  assign rsp_data = rsp_data_reg;
  assign rsp_zero = rsp_zero_reg;
  assign alu_fun  = alu_fun_reg;
  assign alu_in1  = alu_in1_reg;
  assign alu_in2  = alu_in2_reg;

`ifdef ALU_SHARE_MUL_MULTICYCLE_EN
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_reg;  // remaining EXEC cycles after the current one

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= (sel_fun == ALU_MUL) ? CNT_W'(MUL_CYCLES - 1) : '0;
    end else if ((state_reg == ST_EXEC) && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign exec_last = (cnt_reg == '0);
`else
  assign exec_last = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept)    state_next = ST_EXEC;
      ST_EXEC: if (exec_last) state_next = ST_RESP;
      ST_RESP: if (rsp_hs)    state_next = ST_IDLE;
      default:                state_next = ST_IDLE;
    endcase
  end

  // ALU inputs change only on accept, so the ALU stays quiet outside EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg    <= 1'b0;
      alu_fun_reg  <= '0;
      alu_in1_reg  <= '0;
      alu_in2_reg  <= '0;
      rsp_data_reg <= '0;
      rsp_zero_reg <= 1'b0;
    end else begin
      if (accept) begin
        owner_reg   <= grant[1];
        alu_fun_reg <= sel_fun;
        alu_in1_reg <= grant[1] ? req_a_1 : req_a_0;
        alu_in2_reg <= grant[1] ? req_b_1 : req_b_0;
      end
      if ((state_reg == ST_EXEC) && exec_last) begin
        rsp_data_reg <= alu_out;
        rsp_zero_reg <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter with a behavioural MIPS ALU attached behind it.
// Honours ALU_SHARE_MUL_MULTICYCLE_EN for the expected MUL latency.
module tb_alu_share_arbiter;
  import mips_pkg::*;

`ifdef ALU_SHARE_MUL_MULTICYCLE_EN
  localparam int MUL_LAT = 4;
`else
  localparam int MUL_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [2:0]  req_fun_0, req_fun_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic        rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic [2:0]  alu_fun;
  logic [31:0] alu_in1, alu_in2, alu_out;
  logic        alu_zero;

  alu_share_arbiter #(.DATA_W(32), .MUL_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_fun_0(req_fun_0), .req_fun_1(req_fun_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .alu_fun(alu_fun), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  // Behavioural ALU standing in for the real one
  always_comb begin
    alu_out = '0;
    case (alu_fun)
      ALU_AND:  alu_out = alu_in1 & alu_in2;
      ALU_OR:   alu_out = alu_in1 | alu_in2;
      ALU_ADD:  alu_out = alu_in1 + alu_in2;
      ALU_SUB:  alu_out = alu_in1 - alu_in2;
      ALU_MUL:  alu_out = alu_in1 * alu_in2;
      ALU_SLTU: alu_out = {31'b0, (alu_in1 < alu_in2)};
      default:  alu_out = '0;
    endcase
    alu_zero = (alu_out == '0);
  end

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          port;
    logic [2:0]  fun;
    logic [31:0] a, b, data;
    logic        zero;
    int          lat;
  } vec_t;

  typedef struct {
    int          port;
    logic [31:0] data;
    logic        zero;
  } exp_t;

  vec_t vecs[10];
  exp_t sb_q[$];
  int   acc_q[$];
  int   chk_count = 0;
  int   err_count = 0;
  int   t_a, t_b;
  exp_t mon_e;
  int   mon_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_count++;
    if (act !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard: every response handshake is compared against the oldest accepted request
  always @(negedge clk) begin
    if (!rst && ((rsp_valid_0 && rsp_ready_0) || (rsp_valid_1 && rsp_ready_1))) begin
      mon_p = rsp_valid_1 ? 1 : 0;
      chk_count++;
      if (rsp_valid_0 && rsp_valid_1) begin
        err_count++;
        $display("FAIL rsp_both_valid: got 1, expected 0");
      end else if (sb_q.size() == 0) begin
        err_count++;
        $display("FAIL rsp_unexpected: port %0d data 0x%08h with empty scoreboard", mon_p, rsp_data);
      end else begin
        mon_e = sb_q.pop_front();
        $display("rsp port %0d data 0x%08h zero %0b (expected port %0d data 0x%08h zero %0b)",
                 mon_p, rsp_data, rsp_zero, mon_e.port, mon_e.data, mon_e.zero);
        if (mon_p != mon_e.port || rsp_data !== mon_e.data || rsp_zero !== mon_e.zero) begin
          err_count++;
          $display("FAIL rsp_match: got port %0d data 0x%08h zero %0b, expected port %0d data 0x%08h zero %0b",
                   mon_p, rsp_data, rsp_zero, mon_e.port, mon_e.data, mon_e.zero);
        end
      end
    end
  end

  task automatic set_req(input int p, input logic v, input logic [2:0] f, input logic [31:0] a, b);
    if (p == 0) begin
      req_valid_0 = v; req_fun_0 = f; req_a_0 = a; req_b_0 = b;
    end else begin
      req_valid_1 = v; req_fun_1 = f; req_a_1 = a; req_b_1 = b;
    end
  endtask

  // Raise a request, wait for its grant, push the expectation, then drop valid after the accept edge
  task automatic drive_accept(input int p, input logic [2:0] f, input logic [31:0] a, b,
                              input logic [31:0] ed, input logic ez, output int t0);
    bit ok = 1'b0;
    @(negedge clk);
    set_req(p, 1'b1, f, a, b);
    #1;
    for (int k = 0; k < 40; k++) begin
      if ((p == 0) ? req_ready_0 : req_ready_1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    t0 = cyc;
    chk_count++;
    if (!ok) begin
      err_count++;
      $display("FAIL grant_timeout port %0d: req_ready stayed 0, expected 1", p);
    end else begin
      sb_q.push_back('{p, ed, ez});
      acc_q.push_back(p);
      $display("req port %0d fun %03b a 0x%08h b 0x%08h accepted", p, f, a, b);
    end
    @(posedge clk);
    #1;
    set_req(p, 1'b0, f, a, b);
  endtask

  task automatic wait_rsp(input int p, output int got);
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if ((p == 0) ? rsp_valid_0 : rsp_valid_1) begin
        got = 1;
        break;
      end
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60; k++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    chk_count++;
    if (sb_q.size() != 0) begin
      err_count++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic single_op(input vec_t v, input string name);
    int t0, got;
    drive_accept(v.port, v.fun, v.a, v.b, v.data, v.zero, t0);
    wait_rsp(v.port, got);
    chk({name, "_latency"}, got ? (cyc - t0) : -1, v.lat);
    wait_drain();
    @(negedge clk);
    chk({name, "_alu_fun_hold"}, {29'b0, alu_fun}, {29'b0, v.fun});
    chk({name, "_alu_in1_hold"}, alu_in1, v.a);
  endtask

  task automatic both_op(input string name);
    acc_q.delete();
    fork
      drive_accept(0, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, t_a);
      drive_accept(1, ALU_OR, 32'hF0, 32'h0F, 32'hFF, 1'b0, t_b);
    join
    wait_drain();
    chk({name, "_first_grant"}, (acc_q.size() > 0) ? acc_q[0] : -1, 0);
    chk({name, "_second_grant"}, (acc_q.size() > 1) ? acc_q[1] : -1, 1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, "_req_ready"}, {30'b0, req_ready_1, req_ready_0}, 32'd0);
    chk({name, "_rsp_valid"}, {30'b0, rsp_valid_1, rsp_valid_0}, 32'd0);
    chk({name, "_rsp_data"}, rsp_data, 32'd0);
    chk({name, "_rsp_zero"}, {31'b0, rsp_zero}, 32'd0);
    chk({name, "_alu_fun"}, {29'b0, alu_fun}, 32'd0);
    chk({name, "_alu_in1"}, alu_in1, 32'd0);
    chk({name, "_alu_in2"}, alu_in2, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int t0, got;
    vecs[0] = '{0, ALU_ADD,  32'd5,        32'd7,        32'd12,       1'b0, 2};
    vecs[1] = '{1, ALU_AND,  32'hF0F0,     32'h0FF0,     32'h00F0,     1'b0, 2};
    vecs[2] = '{0, ALU_SLTU, 32'd1,        32'hFFFFFFFF, 32'd1,        1'b0, 2};
    vecs[3] = '{1, ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 2};
    vecs[4] = '{0, 3'b011,   32'h1234,     32'h5678,     32'd0,        1'b1, 2};
    vecs[5] = '{1, 3'b111,   32'hDEAD,     32'hBEEF,     32'd0,        1'b1, 2};
    vecs[6] = '{0, ALU_MUL,  32'h10000,    32'h10000,    32'd0,        1'b1, MUL_LAT};
    vecs[7] = '{1, ALU_MUL,  32'd3,        32'd5,        32'd15,       1'b0, MUL_LAT};
    vecs[8] = '{0, ALU_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0, 2};
    vecs[9] = '{1, ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 2};

    rst = 1'b1;
    set_req(0, 1'b0, 3'b000, 32'd0, 32'd0);
    set_req(1, 1'b0, 3'b000, 32'd0, 32'd0);
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs("reset");

    // Round robin from reset: port 0 first, and again after port 1 was served
    both_op("rr_from_reset");
    both_op("rr_repeat");

    for (int i = 0; i < 10; i++) begin
      single_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Response backpressure on port 1 while port 0 waits
    rsp_ready_1 = 1'b0;
    drive_accept(1, ALU_OR, 32'h30, 32'h03, 32'h33, 1'b0, t0);
    wait_rsp(1, got);
    chk("bp_rsp_valid_1", got, 1);
    set_req(0, 1'b1, ALU_ADD, 32'd1, 32'd1);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", {31'b0, rsp_valid_1}, 32'd1);
      chk("bp_hold_data", rsp_data, 32'h33);
      chk("bp_hold_zero", {31'b0, rsp_zero}, 32'd0);
      chk("bp_req_ready_0", {31'b0, req_ready_0}, 32'd0);
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #1 rsp_ready_1 = 1'b1;
    drive_accept(0, ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, t0);
    wait_drain();

    // Reset during EXEC drops the operation
    drive_accept(0, ALU_ADD, 32'd2, 32'd3, 32'd5, 1'b0, t0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk_reset_outputs("rst_exec");
    wait_rsp(0, got);
    chk("rst_exec_no_rsp", got, 0);

    // Reset during RESP drops the held response and restores the pointer
    rsp_ready_0 = 1'b0;
    drive_accept(0, ALU_SUB, 32'd9, 32'd4, 32'd5, 1'b0, t0);
    wait_rsp(0, got);
    chk("rst_resp_reached", got, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    chk_reset_outputs("rst_resp");
    rsp_ready_0 = 1'b1;
    both_op("rr_after_reset");
    single_op(vecs[0], "post_reset_add");

    $display("Simulation finished: %0d checks, %0d errors", chk_count, err_count);
    $finish;
  end

endmodule
